// File: rtl/riscv_nn_regfile_mp.sv
// riscv_nn_regfile_mp: parametrised flip-flop register file with a per-register write scoreboard.
// Define RISCV_NN_REGFILE_BYPASS_EN to forward same-cycle write data and releases to the read ports.
module riscv_nn_regfile_mp #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 32,
  parameter int N_READ     = 3,
  parameter int N_WRITE    = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N_READ*ADDR_WIDTH-1:0]       raddr_i,
  output logic [N_READ*DATA_WIDTH-1:0]       rdata_o,
  output logic [N_READ-1:0]                  rbusy_o,
  input  logic [N_WRITE-1:0]                 we_i,
  input  logic [N_WRITE*ADDR_WIDTH-1:0]      waddr_i,
  input  logic [N_WRITE*DATA_WIDTH-1:0]      wdata_i,
  input  logic                               rsv_valid_i,
  input  logic [ADDR_WIDTH-1:0]              rsv_addr_i,
  output logic                               rsv_ready_o,
  output logic [$clog2(NUM_WORDS+1)-1:0]     pend_cnt_o
);
  localparam int CNT_WIDTH = $clog2(NUM_WORDS + 1);

  logic [DATA_WIDTH-1:0] mem_reg  [NUM_WORDS];
  logic [DATA_WIDTH-1:0] mem_next [NUM_WORDS];
  logic [NUM_WORDS-1:0]  busy_reg;
  logic [NUM_WORDS-1:0]  busy_next;
  logic [NUM_WORDS-1:0]  wr_hit;
  logic [NUM_WORDS-1:0]  set_vec;
  logic [NUM_WORDS-1:0]  clr_vec;
  logic [CNT_WIDTH-1:0]  cnt_reg;
  logic [CNT_WIDTH-1:0]  cnt_next;
  logic                  rsv_fire;

  // Ports scanned in ascending order so the highest-index port wins a collision.
  // Index 0 and out-of-range addresses never match, so those writes vanish.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NUM_WORDS; i++) mem_next[i] = mem_reg[i];
    for (int w = 0; w < N_WRITE; w++) begin
      for (int i = 1; i < NUM_WORDS; i++) begin
        if (we_i[w] && waddr_i[w*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(i)) begin
          wr_hit[i]   = 1'b1;
          mem_next[i] = wdata_i[w*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_comb begin
    rsv_ready_o = 1'b1;
    for (int i = 1; i < NUM_WORDS; i++) begin
      if (rsv_addr_i == ADDR_WIDTH'(i) && busy_reg[i] && !wr_hit[i]) rsv_ready_o = 1'b0;
    end
  end

  assign rsv_fire = rsv_valid_i && rsv_ready_o;

  always_comb begin
    set_vec = '0;
    for (int i = 1; i < NUM_WORDS; i++) begin
      if (rsv_fire && rsv_addr_i == ADDR_WIDTH'(i)) set_vec[i] = 1'b1;
    end
  end

  // A reservation landing on a register being released keeps it busy.
  assign clr_vec   = busy_reg & wr_hit;
  assign busy_next = (busy_reg & ~clr_vec) | set_vec;

  always_comb begin
    cnt_next = cnt_reg;
    for (int i = 1; i < NUM_WORDS; i++) begin
      if (set_vec[i] && !busy_reg[i]) cnt_next = cnt_next + CNT_WIDTH'(1);
      if (clr_vec[i] && !set_vec[i])  cnt_next = cnt_next - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_WORDS; i++) mem_reg[i] <= '0;
      busy_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      for (int i = 0; i < NUM_WORDS; i++) mem_reg[i] <= mem_next[i];
      busy_reg <= busy_next;
      cnt_reg  <= cnt_next;
    end
  end

  assign pend_cnt_o = cnt_reg;

  for (genvar gi = 0; gi < N_READ; gi++) begin : g_read
    logic [ADDR_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rbusy;

    assign raddr = raddr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      rdata = '0;
      rbusy = 1'b0;
      for (int i = 1; i < NUM_WORDS; i++) begin
        if (raddr == ADDR_WIDTH'(i)) begin
`ifdef RISCV_NN_REGFILE_BYPASS_EN
          rdata = mem_next[i];
          rbusy = busy_reg[i] && !(clr_vec[i] && !set_vec[i]);
`else
          rdata = mem_reg[i];
          rbusy = busy_reg[i];
`endif
        end
      end
    end

    assign rdata_o[gi*DATA_WIDTH +: DATA_WIDTH] = rdata;
    assign rbusy_o[gi]                          = rbusy;
  end

endmodule

// File: tb/tb_riscv_nn_regfile_mp.sv
// Randomised and directed bench for riscv_nn_regfile_mp against an array-based register/scoreboard model.
module tb_riscv_nn_regfile_mp;
  localparam int AW  = 5;
  localparam int DW  = 32;
  localparam int NW  = 32;
  localparam int NR  = 3;
  localparam int NWR = 2;
  localparam int CW  = $clog2(NW + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rbusy;
  logic [NWR-1:0]   we;
  logic [NWR*AW-1:0] waddr;
  logic [NWR*DW-1:0] wdata;
  logic             rsv_valid;
  logic [AW-1:0]    rsv_addr;
  logic             rsv_ready;
  logic [CW-1:0]    pend_cnt;

  always #5 clk = ~clk;

  riscv_nn_regfile_mp #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(NW), .N_READ(NR), .N_WRITE(NWR)
  ) dut (
    .clk(clk), .rst(rst),
    .raddr_i(raddr), .rdata_o(rdata), .rbusy_o(rbusy),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .rsv_valid_i(rsv_valid), .rsv_addr_i(rsv_addr), .rsv_ready_o(rsv_ready),
    .pend_cnt_o(pend_cnt)
  );

  logic [DW-1:0] m_mem  [NW];
  bit            m_busy [NW];
  int            n_checks = 0;
  int            n_pass   = 0;
  int            cyc      = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic bit valid_addr(int a);
    return a != 0 && a < NW;
  endfunction

  function automatic int write_winner(int a);
    int r = -1;
    for (int w = 0; w < NWR; w++)
      if (we[w] && int'(waddr[w*AW +: AW]) == a) r = w;
    return r;
  endfunction

  function automatic int model_pending();
    int n = 0;
    for (int i = 0; i < NW; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  // Check all outputs against the model, then advance the model and the DUT one clock.
  task automatic step(string what);
    int  a;
    int  ra;
    bit  exp_rdy;
    bit  fire;
    logic [DW-1:0] ed;
    bit  eb;
    #1;
    ra      = int'(rsv_addr);
    exp_rdy = !(valid_addr(ra) && m_busy[ra] && write_winner(ra) < 0);
    fire    = rsv_valid && exp_rdy;
    for (int p = 0; p < NR; p++) begin
      a  = int'(raddr[p*AW +: AW]);
      ed = '0;
      eb = 1'b0;
      if (valid_addr(a)) begin
        ed = m_mem[a];
        eb = m_busy[a];
`ifdef RISCV_NN_REGFILE_BYPASS_EN
        if (write_winner(a) >= 0) begin
          ed = wdata[write_winner(a)*DW +: DW];
          eb = m_busy[a] && fire && ra == a;
        end
`endif
      end
      check($sformatf("rdata%0d", p), 64'(rdata[p*DW +: DW]), 64'(ed));
      check($sformatf("rbusy%0d", p), 64'(rbusy[p]), 64'(eb));
    end
    check("rsv_ready", 64'(rsv_ready), 64'(exp_rdy));
    check("pend_cnt", 64'(pend_cnt), 64'(model_pending()));
    $display("cyc %0d %s rst=%0b we=%b waddr=%h rsv=%0b@%0d rdy=%0b pend=%0d",
             cyc, what, rst, we, waddr, rsv_valid, ra, rsv_ready, pend_cnt);
    if (rst) begin
      for (int i = 0; i < NW; i++) begin m_mem[i] = '0; m_busy[i] = 1'b0; end
    end else begin
      for (int w = 0; w < NWR; w++) begin
        a = int'(waddr[w*AW +: AW]);
        if (we[w] && valid_addr(a)) begin
          m_mem[a]  = wdata[w*DW +: DW];
          m_busy[a] = 1'b0;
        end
      end
      if (fire && valid_addr(ra)) m_busy[ra] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drive_idle();
    rst = 1'b0; we = '0; waddr = '0; wdata = '0; rsv_valid = 1'b0; rsv_addr = '0;
  endtask

  task automatic set_read(int p, int a);
    raddr[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_write(int w, int a, logic [DW-1:0] d);
    we[w] = 1'b1; waddr[w*AW +: AW] = AW'(a); wdata[w*DW +: DW] = d;
  endtask

  task automatic reserve(int a);
    rsv_valid = 1'b1; rsv_addr = AW'(a);
  endtask

  initial begin
    raddr = '0;
    drive_idle();
    for (int i = 0; i < NW; i++) begin m_mem[i] = '0; m_busy[i] = 1'b0; end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // All addresses on all ports read zero and idle after reset.
    for (int a = 0; a < NW; a++) begin
      for (int p = 0; p < NR; p++) set_read(p, a);
      step("rd_reset");
    end

    // Collision on x5: port 1 wins; writes to x0 are dropped.
    set_write(0, 5, 32'hDEADBEEF); set_write(1, 5, 32'h12345678);
    step("wr_collide");
    drive_idle(); set_read(0, 5); set_read(1, 0);
    #1 check("x5_collision", 64'(rdata[0 +: DW]), 64'h12345678);
    step("rd_x5");
    set_write(0, 0, 32'hFFFFFFFF);
    step("wr_x0");
    drive_idle();
    #1 check("x0_zero", 64'(rdata[DW +: DW]), 64'h0);
    step("rd_x0");

    // Scoreboard reserve/release.
    reserve(7); step("rsv_x7");
    reserve(9); step("rsv_x9");
    drive_idle(); set_read(0, 7);
    #1 check("pend_two", 64'(pend_cnt), 64'd2);
    check("x7_busy", 64'(rbusy[0]), 64'd1);
    step("rd_x7");
    reserve(7);
    #1 check("x7_rsv_blocked", 64'(rsv_ready), 64'd0);
    step("rsv_x7_again");
    drive_idle(); set_write(1, 7, 32'h00000777);
    step("wr_x7");
    drive_idle();
    #1 check("pend_after_release", 64'(pend_cnt), 64'd1);
    step("idle");

    // Release and reservation of x9 in the same cycle: reservation wins.
    set_write(0, 9, 32'h99); reserve(9);
    step("wr_rsv_x9");
    drive_idle(); set_read(2, 9);
    #1 check("pend_same_cycle", 64'(pend_cnt), 64'd1);
    check("x9_still_busy", 64'(rbusy[2]), 64'd1);
    step("rd_x9");

    // Reset discards a pending write and reservation.
    reserve(3); step("rsv_x3");
    drive_idle(); rst = 1'b1; set_write(0, 3, 32'hAA); reserve(3);
    step("rst_pending");
    drive_idle(); set_read(1, 3);
    #1 check("x3_after_rst", 64'(rdata[DW +: DW]), 64'h0);
    check("x3_busy_after_rst", 64'(rbusy[1]), 64'd0);
    check("pend_after_rst", 64'(pend_cnt), 64'd0);
    step("rd_x3");

    // Read-during-write on port 2.
    set_write(0, 4, 32'h55); set_read(2, 4);
`ifdef RISCV_NN_REGFILE_BYPASS_EN
    #1 check("x4_rdw", 64'(rdata[2*DW +: DW]), 64'h55);
`else
    #1 check("x4_rdw", 64'(rdata[2*DW +: DW]), 64'h0);
`endif
    step("wr_rd_x4");
    drive_idle();

    // Randomised traffic concentrated on a few registers to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int p = 0; p < NR; p++)
        set_read(p, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NW - 1)) : int'($urandom_range(0, 10)));
      for (int w = 0; w < NWR; w++) begin
        we[w] = ($urandom_range(0, 2) == 0);
        waddr[w*AW +: AW] = AW'($urandom_range(0, 10));
        wdata[w*DW +: DW] = $urandom;
      end
      rsv_valid = $urandom_range(0, 1) == 1;
      rsv_addr  = AW'($urandom_range(0, 10));
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/riscv_nn_regfile_mp.md
Name: riscv_nn_regfile_mp

Overview:
- Parametrised flip-flop register file, successor to the fixed 3-read/2-write latch register file.
- Configurable depth, width, read-port count and write-port count.
- Built-in write scoreboard: reserve/release bits mark registers with an outstanding write (long-latency NN/LSU results), so the ID stage can stall on busy operands.
- Sits between ID (reads, reserves) and EX/WB (writes).

Parameters:
- ADDR_WIDTH, 5: register address width.
- DATA_WIDTH, 32: register width.
- NUM_WORDS, 32: number of registers, at most 2**ADDR_WIDTH. Register 0 is hardwired to zero.
- N_READ, 3: number of read ports, 1 to 4.
- N_WRITE, 2: number of write ports, 1 to 3.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- raddr_i, in, N_READ*ADDR_WIDTH: read addresses; port p uses slice [p*ADDR_WIDTH +: ADDR_WIDTH].
- rdata_o, out, N_READ*DATA_WIDTH: read data, packed the same way.
- rbusy_o, out, N_READ: per read port, 1 when the addressed register has an outstanding reservation.
- we_i, in, N_WRITE: write enables.
- waddr_i, in, N_WRITE*ADDR_WIDTH: write addresses.
- wdata_i, in, N_WRITE*DATA_WIDTH: write data.
- rsv_valid_i, in, 1: request to reserve a register.
- rsv_addr_i, in, ADDR_WIDTH: register to reserve.
- rsv_ready_o, out, 1: reservation can be accepted this cycle.
- pend_cnt_o, out, $clog2(NUM_WORDS+1): number of registers currently reserved.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. While rst=1 at a rising edge, all registers, busy bits and pend_cnt_o go to 0; writes and reservations in that cycle are discarded.
- After reset, every rdata_o reads 0, rbusy_o=0, rsv_ready_o=1 (when rsv_addr_i is not busy), pend_cnt_o=0.
- Reads: combinational, zero latency. Register 0 and addresses >= NUM_WORDS read 0 and are never busy.
- Writes: take effect at the rising edge when we_i[w]=1. Writes to address 0 or to addresses >= NUM_WORDS are ignored.
- Write collision (several ports, same address, same cycle): the highest-index port wins.
- Read-during-write: returns the old value (see Optional Feature).
- Scoreboard handshake: a reservation is accepted when rsv_valid_i && rsv_ready_o. It sets busy[rsv_addr_i] at the next edge.
- rsv_ready_o = !busy[rsv_addr_i], or the register is being released by any write in the same cycle.
- Reserving address 0 is always accepted and has no effect.
- Release: any enabled write to a busy register clears its busy bit at the edge, including a write from a port that lost a collision.
- Simultaneous release and accepted reservation of the same address: reservation wins, bit stays 1, count unchanged.
- Writes to non-busy registers do not affect the scoreboard.
- pend_cnt_o = popcount of the busy bits, kept as a registered counter. It is updated by +1 per new set, -1 per cleared bit and never wraps; a maximum of NUM_WORDS-1 is reachable.
- No FSM beyond the per-register busy bits. All state is flip-flops; no latches or clock gating.

Optional Feature:
- Macro: RISCV_NN_REGFILE_BYPASS_EN.
- Defined: a read whose address matches an enabled write in the same cycle returns that write's data (winning port under collisions) instead of the stored value. rbusy_o for that port is forced to 0 if the write releases the register.
- Undefined: reads return the stored value only; rbusy_o reflects the registered busy bits.

Test Plan:
- Reset, then read all 32 addresses on all ports -> all rdata_o=0, rbusy_o=0, pend_cnt_o=0.
- Port0 writes x5=0xDEADBEEF and port1 writes x5=0x12345678 in the same cycle -> next cycle x5 reads 0x12345678. A write of 0xFFFFFFFF to x0 -> x0 still reads 0.
- Reserve x7, then x9 -> pend_cnt_o=2; reading x7 gives rbusy_o=1. A second reserve of x7 -> rsv_ready_o=0. A write to x7 -> busy clears, pend_cnt_o=1.
- Same cycle: write x9 and reserve x9 -> x9 stays busy, pend_cnt_o unchanged (1).
- Assert rst with x3 reserved and a write to x3=0xAA pending -> after the edge, x3 reads 0, busy=0, pend_cnt_o=0.
- Write x4=0x55 while port2 reads x4 in the same cycle -> with BYPASS_EN rdata=0x55, without it rdata=old value (0).
